// File: rtl/mem_rw_responder_pkg.sv
// Shared widths and state encodings for the mem_rw_responder slice.
package mem_rw_pkg;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 64;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Selects where the registered read word comes from.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_MEM,
    SRC_BYP
  } rd_src_t;
endpackage

// File: rtl/mem_rw_responder_if.sv
// Read/write request bus between a requester and mem_rw_responder.
interface mem_rw_responder_if;
  import mem_rw_pkg::*;
  logic              r_enable;
  logic [IDX_W-1:0]  r_index;
  logic [DATA_W-1:0] r_data;
  logic              w_enable;
  logic [IDX_W-1:0]  w_index;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] w_mask;

  modport master (
    output r_enable, r_index, w_enable, w_index, w_data, w_mask,
    input  r_data
  );

  modport slave (
    input  r_enable, r_index, w_enable, w_index, w_data, w_mask,
    output r_data
  );
endinterface

// File: rtl/mem_rw_responder_array.sv
// Word storage: one synchronous read port, one bit-masked write port.
module mem_rw_array
  import mem_rw_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] wmask,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read samples the pre-write word when both ports hit the same address.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask);
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_rw_responder.sv
// Memory responder: init sweep FSM, range checking and sticky error flag.
// Optional macro MEM_RW_BYPASS_EN forwards same-cycle same-index writes to the read data.
module mem_rw_responder
  import mem_rw_pkg::*;
#(
  parameter int                DEPTH      = 4096,
  parameter logic [DATA_W-1:0] INIT_VALUE = 64'h0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  mem_rw_responder_if.slave bus,
  output logic              init_done,
  output logic              oor_err
);
  localparam int             AW        = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
  localparam logic [AW-1:0]  LAST_IDX  = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     cnt;
  rd_src_t           src_p1;
  logic [DATA_W-1:0] rd_word_p1;

  logic rd_req, wr_req, rd_oor, wr_oor, rd_ok, wr_ok, byp_hit;

  logic              arr_we;
  logic [AW-1:0]     arr_waddr;
  logic [DATA_W-1:0] arr_wdata, arr_wmask;

  // Requests are only live in RUN and never in a cycle where reset is asserted.
  assign rd_req = !reset && (state == RUN) && enable && bus.r_enable;
  assign wr_req = !reset && (state == RUN) && enable && bus.w_enable;
  assign rd_oor = bus.r_index >= DEPTH_IDX;
  assign wr_oor = bus.w_index >= DEPTH_IDX;
  assign rd_ok  = rd_req && !rd_oor;
  assign wr_ok  = wr_req && !wr_oor;

`ifdef MEM_RW_BYPASS_EN
  logic [DATA_W-1:0] byp_data_p1, byp_mask_p1;
  assign byp_hit = rd_ok && wr_ok && (bus.r_index == bus.w_index);
`else
  assign byp_hit = 1'b0;
`endif

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = bus.w_index[AW-1:0];
    arr_wdata = bus.w_data;
    arr_wmask = bus.w_mask;
    if (state == INIT) begin
      arr_we    = !reset;
      arr_waddr = cnt;
      arr_wdata = INIT_VALUE;
      arr_wmask = '1;
    end else begin
      arr_we    = wr_ok;
    end
  end

  mem_rw_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .wmask (arr_wmask),
    .re    (rd_ok),
    .raddr (bus.r_index[AW-1:0]),
    .rdata (rd_word_p1)
  );

  // p0 -> p1: control registers; source select holds until the next accepted read.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      oor_err   <= 1'b0;
      src_p1    <= SRC_ZERO;
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if ((rd_req && rd_oor) || (wr_req && wr_oor)) oor_err <= 1'b1;
          if (rd_req) begin
            if (rd_oor)       src_p1 <= SRC_ZERO;
            else if (byp_hit) src_p1 <= SRC_BYP;
            else              src_p1 <= SRC_MEM;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef MEM_RW_BYPASS_EN
  always_ff @(posedge clock) begin
    if (byp_hit) begin
      byp_data_p1 <= bus.w_data;
      byp_mask_p1 <= bus.w_mask;
    end
  end
`endif

  always_comb begin
    case (src_p1)
      SRC_MEM: bus.r_data = rd_word_p1;
`ifdef MEM_RW_BYPASS_EN
      SRC_BYP: bus.r_data = (rd_word_p1 & ~byp_mask_p1) | (byp_data_p1 & byp_mask_p1);
`endif
      default: bus.r_data = '0;
    endcase
  end
endmodule

// File: tb/tb_mem_rw_responder.sv
// Directed testbench for mem_rw_responder with DEPTH=16, INIT_VALUE=64'hA5A5.
module tb_mem_rw_responder;
  localparam int          DEPTH = 16;
  localparam logic [63:0] IV    = 64'hA5A5;

  logic clock = 1'b0;
  logic reset, enable, init_done, oor_err;
  int checks = 0;
  int errors = 0;

  mem_rw_responder_if bus ();

  mem_rw_responder #(.DEPTH(DEPTH), .INIT_VALUE(IV)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .init_done (init_done),
    .oor_err   (oor_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.r_enable = 1'b0;
    bus.w_enable = 1'b0;
    bus.r_index  = '0;
    bus.w_index  = '0;
    bus.w_data   = '0;
    bus.w_mask   = '0;
  endtask

  task automatic do_write(input logic [63:0] idx, input logic [63:0] data, input logic [63:0] mask);
    idle();
    bus.w_enable = 1'b1;
    bus.w_index  = idx;
    bus.w_data   = data;
    bus.w_mask   = mask;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [63:0] idx);
    idle();
    bus.r_enable = 1'b1;
    bus.r_index  = idx;
    tick();
    idle();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (bus.r_data !== 64'h0) begin errors++; $display("FAIL reset_r_data: got %h expected %h", bus.r_data, 64'h0); end
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL reset_oor_err: got %b expected 0", oor_err); end
    reset = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL init_early: cycle %0d got %b expected 0", i + 1, init_done); end
    end
    tick();
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b expected 1", init_done); end
  endtask

  task automatic test_init_value();
    do_read(64'd7);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL init_read7: got %h expected %h", bus.r_data, IV); end
    do_read(64'd15);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL init_read15: got %h expected %h", bus.r_data, IV); end
  endtask

  task automatic test_masked_write();
    do_write(64'd3, 64'h0, '1);
    do_write(64'd3, 64'h1122334455667788, 64'h00000000FFFFFFFF);
    do_read(64'd3);
    checks++;
    if (bus.r_data !== 64'h0000000055667788) begin errors++; $display("FAIL masked_write: got %h expected %h", bus.r_data, 64'h0000000055667788); end
    do_write(64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    do_read(64'd3);
    checks++;
    if (bus.r_data !== 64'h0000000055667788) begin errors++; $display("FAIL zero_mask: got %h expected %h", bus.r_data, 64'h0000000055667788); end
  endtask

  task automatic test_rw_diff();
    idle();
    bus.w_enable = 1'b1; bus.w_index = 64'd9; bus.w_data = 64'hCAFE; bus.w_mask = '1;
    bus.r_enable = 1'b1; bus.r_index = 64'd3;
    tick();
    idle();
    checks++;
    if (bus.r_data !== 64'h0000000055667788) begin errors++; $display("FAIL rw_diff_read: got %h expected %h", bus.r_data, 64'h0000000055667788); end
    do_read(64'd9);
    checks++;
    if (bus.r_data !== 64'hCAFE) begin errors++; $display("FAIL rw_diff_write: got %h expected %h", bus.r_data, 64'hCAFE); end
  endtask

  task automatic test_same_index();
    logic [63:0] exp_same;
`ifdef MEM_RW_BYPASS_EN
    exp_same = 64'hFF;
`else
    exp_same = 64'h0;
`endif
    do_write(64'd5, 64'h0, '1);
    idle();
    bus.w_enable = 1'b1; bus.w_index = 64'd5; bus.w_data = 64'hFF; bus.w_mask = '1;
    bus.r_enable = 1'b1; bus.r_index = 64'd5;
    tick();
    idle();
    checks++;
    if (bus.r_data !== exp_same) begin errors++; $display("FAIL same_index: got %h expected %h", bus.r_data, exp_same); end
    tick();
    checks++;
    if (bus.r_data !== exp_same) begin errors++; $display("FAIL same_index_hold: got %h expected %h", bus.r_data, exp_same); end
    do_read(64'd5);
    checks++;
    if (bus.r_data !== 64'hFF) begin errors++; $display("FAIL same_index_after: got %h expected %h", bus.r_data, 64'hFF); end
  endtask

  task automatic test_oor();
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL oor_before: got %b expected 0", oor_err); end
    do_read(64'd16);
    checks++;
    if (bus.r_data !== 64'h0) begin errors++; $display("FAIL oor_read: got %h expected %h", bus.r_data, 64'h0); end
    checks++;
    if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_flag: got %b expected 1", oor_err); end
    do_write(64'h1_0000_0000, 64'hDEAD, '1);
    do_read(64'd0);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL oor_write_dropped: got %h expected %h", bus.r_data, IV); end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (oor_err !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", oor_err); end
  endtask

  task automatic test_enable_low();
    do_read(64'd7);
    enable = 1'b0;
    idle();
    bus.w_enable = 1'b1; bus.w_index = 64'd7; bus.w_data = 64'h1234; bus.w_mask = '1;
    bus.r_enable = 1'b1; bus.r_index = 64'd9;
    tick();
    tick();
    idle();
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL enable_low_hold: got %h expected %h", bus.r_data, IV); end
    enable = 1'b1;
    do_read(64'd7);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL enable_low_nowrite: got %h expected %h", bus.r_data, IV); end
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b1;
    idle();
    tick();
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL rst_oor_clear: got %b expected 0", oor_err); end
    reset = 1'b0;
    bus.w_enable = 1'b1; bus.w_index = 64'd1; bus.w_data = 64'h1234; bus.w_mask = '1;
    bus.r_enable = 1'b1; bus.r_index = 64'd9;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (bus.r_data !== 64'h0) begin errors++; $display("FAIL init_read_ignored: got %h expected %h", bus.r_data, 64'h0); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      checks++;
      if (init_done !== 1'b0) begin errors++; $display("FAIL restart_early: cycle %0d got %b expected 0", i + 1, init_done); end
    end
    tick();
    idle();
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", init_done); end
    checks++;
    if (bus.r_data !== 64'h0) begin errors++; $display("FAIL restart_r_data: got %h expected %h", bus.r_data, 64'h0); end
    checks++;
    if (oor_err !== 1'b0) begin errors++; $display("FAIL restart_oor: got %b expected 0", oor_err); end
    do_read(64'd1);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL init_write_ignored: got %h expected %h", bus.r_data, IV); end
    do_read(64'd3);
    checks++;
    if (bus.r_data !== IV) begin errors++; $display("FAIL sweep_restored: got %h expected %h", bus.r_data, IV); end
  endtask

  initial begin
    test_reset();
    test_init_value();
    test_masked_write();
    test_rw_diff();
    test_same_index();
    test_oor();
    test_enable_low();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
